cross_bar_port_arbiter: RTL and testbench

Round-robin output-port arbiter for the `cross_bar` fabric. It selects one of `REQUESTERS` input FIFOs (show-ahead) heading for one output port and pops the chosen FIFO. The selected beat goes into a registered output stage with `valid`/`stall` backpressure. Multi-beat packets are kept contiguous by locking onto the owning requester until its `last` beat. One instance sits on each crossbar output.

---
 rtl/cross_bar_port_arbiter.sv | 116 +++++++++++
 tb/tb_cross_bar_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cross_bar_port_arbiter: round-robin output-port arbiter with packet lock    |
// | and a registered valid/stall output stage.                                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cross_bar_port_arbiter #(
    parameter int REQUESTERS = 8,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [0:REQUESTERS-1]         req,
    input  logic [REQUESTERS*WIDTH-1:0]   d,
    input  logic [0:REQUESTERS-1]         last,
    output logic [0:REQUESTERS-1]         gnt,
    output logic                          valid,
    output logic [WIDTH-1:0]              q,
    input  logic                          stall,
    output logic                          locked,
    output logic [$clog2(REQUESTERS)-1:0] owner
);

    localparam int IW = $clog2(REQUESTERS);

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             valid_q;
    logic [WIDTH-1:0] q_q;

    logic             adv;
    logic             found;
    logic             grant;
    logic [IW-1:0]    sel_idx;
    logic [IW:0]      cand;

    assign adv = !valid_q || !stall;

    // Candidate search; a lock restricts eligibility to the current owner.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        if (state_q == ST_LOCKED) begin
            found   = req[owner_q];
            sel_idx = owner_q;
        end else begin
            for (int k = 0; k < REQUESTERS; k++) begin
                cand = {1'b0, ptr_q} + (IW+1)'(k);
                if (cand >= (IW+1)'(REQUESTERS)) begin
                    cand = cand - (IW+1)'(REQUESTERS);
                end
                if (!found && req[cand[IW-1:0]]) begin
                    found   = 1'b1;
                    sel_idx = cand[IW-1:0];
                end
            end
        end
    end

    assign grant = rst && adv && found;

    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (grant) begin
            owner_d = sel_idx;
            ptr_d   = (sel_idx == IW'(REQUESTERS-1)) ? '0 : sel_idx + IW'(1);
            state_d = last[sel_idx] ? ST_ARB : ST_LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Output stage: load on grant, drain when downstream takes the beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            q_q     <= '0;
        end else if (grant) begin
            valid_q <= 1'b1;
            q_q     <= d[WIDTH*sel_idx +: WIDTH];
        end else if (adv) begin
            valid_q <= 1'b0;
        end
    end

    assign valid  = valid_q;
    assign q      = q_q;
    assign locked = (state_q == ST_LOCKED);
    assign owner  = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_cross_bar_port_arbiter.sv
`default_nettype none
// Directed self-checking bench for cross_bar_port_arbiter (8 requesters, 8-bit beats).
module tb_cross_bar_port_arbiter;

    localparam int N = 8;
    localparam int W = 8;
    localparam int NONE = 15;

    logic           clk;
    logic           rst;
    logic [0:N-1]   req;
    logic [N*W-1:0] d;
    logic [0:N-1]   last;
    logic [0:N-1]   gnt;
    logic           valid;
    logic [W-1:0]   q;
    logic           stall;
    logic           locked;
    logic [2:0]     owner;

    int n_cmp = 0;
    int n_err = 0;

    cross_bar_port_arbiter #(.REQUESTERS(N), .WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .d      (d),
        .last   (last),
        .gnt    (gnt),
        .valid  (valid),
        .q      (q),
        .stall  (stall),
        .locked (locked),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Index of the single set bit, NONE when idle, 14 when more than one is set.
    function automatic int gnt_code(input logic [0:N-1] g);
        int n = 0;
        int idx = NONE;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                n++;
                idx = i;
            end
        end
        if (n > 1) idx = 14;
        return idx;
    endfunction

    // Maps an LSB-numbered mask (bit i = requester i) onto the [0:N-1] port.
    function automatic logic [0:N-1] bits8(input logic [7:0] m);
        logic [0:N-1] r;
        for (int i = 0; i < N; i++) r[i] = m[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sb[$];
    logic       m_valid;
    logic [7:0] m_q;
    logic       m_adv;
    int         e;

    initial begin
        rst   = 1'b0;
        req   = bits8(8'hFF);
        last  = '1;
        stall = 1'b0;
        for (int i = 0; i < N; i++) d[W*i +: W] = 8'(i + 1);

        // Reset held for three cycles with everyone requesting.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst_gnt", gnt_code(gnt), NONE);
            check_eq("rst_valid", 32'(valid), 0);
            check_eq("rst_q", 32'(q), 0);
            check_eq("rst_locked", 32'(locked), 0);
        end

        // Round-robin over single-beat packets.
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_eq("rr_gnt", gnt_code(gnt), c % 8);
            tick();
            check_eq("rr_valid", 32'(valid), 1);
            check_eq("rr_q", 32'(q), (c % 8) + 1);
        end

        // Packet lock: requester 2 sends three beats, requester 5 competes.
        req = bits8(8'b0010_0100);
        last[2] = 1'b0;
        #1;
        check_eq("lk_gnt_b1", gnt_code(gnt), 2);
        check_eq("lk_unlocked_pre", 32'(locked), 0);
        tick();
        check_eq("lk_locked_b1", 32'(locked), 1);
        check_eq("lk_q_b1", 32'(q), 3);
        #1;
        check_eq("lk_gnt_b2", gnt_code(gnt), 2);
        tick();
        check_eq("lk_locked_b2", 32'(locked), 1);
        check_eq("lk_owner", 32'(owner), 2);
        req[2] = 1'b0;
        #1;
        check_eq("lk_bubble_gnt", gnt_code(gnt), NONE);
        tick();
        check_eq("lk_bubble_valid", 32'(valid), 0);
        check_eq("lk_bubble_locked", 32'(locked), 1);
        check_eq("lk_bubble_q", 32'(q), 3);
        req[2]  = 1'b1;
        last[2] = 1'b1;
        #1;
        check_eq("lk_gnt_b3", gnt_code(gnt), 2);
        tick();
        check_eq("lk_released", 32'(locked), 0);
        #1;
        check_eq("lk_gnt_next", gnt_code(gnt), 5);
        tick();
        check_eq("lk_q_next", 32'(q), 6);
        check_eq("lk_owner_next", 32'(owner), 5);

        // Backpressure on a full stream, tracked by a scoreboard.
        req = bits8(8'hFF);
        sb = {};
        sb.push_back(8'd6);
        m_valid = 1'b1;
        m_q = 8'd6;
        e = 6;
        for (int c = 0; c < 12; c++) begin
            stall = (c >= 3 && c <= 6);
            #1;
            m_adv = !m_valid || !stall;
            check_eq("bp_gnt", gnt_code(gnt), m_adv ? e : NONE);
            if (valid && !stall) begin
                if (sb.size() == 0) begin
                    check_eq("bp_sb_empty", 32'(q), 32'hFFFF);
                end else begin
                    check_eq("bp_sb_beat", 32'(q), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            tick();
            if (m_adv) begin
                m_q = 8'(e + 1);
                m_valid = 1'b1;
                sb.push_back(8'(e + 1));
                e = (e + 1) % 8;
            end
            check_eq("bp_valid", 32'(valid), 32'(m_valid));
            check_eq("bp_q", 32'(q), 32'(m_q));
        end
        stall = 1'b0;
        check_eq("bp_sb_depth", sb.size(), 1);

        // Wrap and sparse requests: grant 7, then 2, 7, 0.
        req = bits8(8'b1000_0000);
        #1;
        check_eq("wr_gnt7", gnt_code(gnt), 7);
        tick();
        req = bits8(8'b0000_0100);
        #1;
        check_eq("wr_gnt2", gnt_code(gnt), 2);
        tick();
        check_eq("wr_q2", 32'(q), 3);
        req = bits8(8'b1000_0001);
        #1;
        check_eq("wr_gnt7b", gnt_code(gnt), 7);
        tick();
        check_eq("wr_q7", 32'(q), 8);
        #1;
        check_eq("wr_gnt0", gnt_code(gnt), 0);
        tick();
        check_eq("wr_q0", 32'(q), 1);

        // Reset while locked on requester 4.
        req = bits8(8'b0001_0000);
        last[4] = 1'b0;
        #1;
        check_eq("mr_gnt4", gnt_code(gnt), 4);
        tick();
        check_eq("mr_locked", 32'(locked), 1);
        check_eq("mr_owner", 32'(owner), 4);
        rst = 1'b0;
        #1;
        check_eq("mr_rst_gnt", gnt_code(gnt), NONE);
        tick();
        check_eq("mr_locked_clr", 32'(locked), 0);
        check_eq("mr_valid_clr", 32'(valid), 0);
        rst = 1'b1;
        req = bits8(8'b0001_0001);
        last = '1;
        #1;
        check_eq("mr_gnt0", gnt_code(gnt), 0);
        tick();
        check_eq("mr_q0", 32'(q), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
